load_store_unit: RTL and testbench

- Sits between the multi-cycle RV32I core's MEMORY stage and the 32-bit single-port-style BRAM (synchronous read, 1-cycle latency, no byte enables).
- Consumes the core's load/store requests. Performs read-modify-write for SB/SH.
- Returns aligned, sign- or zero-extended load data. Flags misaligned or illegal accesses without touching memory.

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_byte_lane.sv | 56 +++++
 rtl/load_store_unit.sv | 125 ++++++++++++
 tb/tb_load_store_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and legality helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4,
    ERR  = 3'd5
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Stores only exist in signed-size form; loads also allow the unsigned variants.
  function automatic logic is_legal(input logic store, input logic [2:0] funct3);
    if (store) return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
           (funct3 == F3_BU) || (funct3 == F3_HU);
  endfunction

  // Access size lives in funct3[1:0]: 00 byte, 01 half, 10 word.
  function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b01:   return !addr_lo[0];
      2'b10:   return (addr_lo == 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte/half lane steering: extracts and extends load data, and merges store
// data into a read word for read-modify-write.
module lsu_byte_lane
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] word,
  input  logic [1:0]       lane,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed byte/half, extend it, and splice new data into the word.
  always_comb begin
    byte_sel   = word[7:0];
    half_sel   = word[15:0];
    load_value = word;
    store_word = wdata;
    case (funct3[1:0])
      2'b00: begin
        store_word = word;
        case (lane)
          2'b00: begin byte_sel = word[7:0];   store_word[7:0]   = wdata[7:0]; end
          2'b01: begin byte_sel = word[15:8];  store_word[15:8]  = wdata[7:0]; end
          2'b10: begin byte_sel = word[23:16]; store_word[23:16] = wdata[7:0]; end
          default: begin byte_sel = word[31:24]; store_word[31:24] = wdata[7:0]; end
        endcase
        load_value = funct3[2] ? {{(WIDTH-8){1'b0}}, byte_sel}
                               : {{(WIDTH-8){byte_sel[7]}}, byte_sel};
      end
      2'b01: begin
        store_word = word;
        if (lane[1]) begin
          half_sel           = word[31:16];
          store_word[31:16]  = wdata[15:0];
        end else begin
          half_sel           = word[15:0];
          store_word[15:0]   = wdata[15:0];
        end
        load_value = funct3[2] ? {{(WIDTH-16){1'b0}}, half_sel}
                               : {{(WIDTH-16){half_sel[15]}}, half_sel};
      end
      default: begin
        load_value = word;
        store_word = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a 1-cycle-latency BRAM without byte
// enables. Sub-word stores are done as read-modify-write; one request at a time.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              resp_valid,
  output logic [WIDTH-1:0]  resp_rdata,
  output logic              resp_error,
  output logic              mem_read_enable,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata
);

  state_t           state;
  logic [1:0]       cap_lane;
  logic [2:0]       cap_funct3;
  logic             cap_store;
  logic [WIDTH-1:0] cap_wdata;
  logic [WIDTH-1:0] lane_load;
  logic [WIDTH-1:0] lane_merged;
  logic             req_ok;

  // Upper address bits are deliberately ignored so accesses wrap modulo the BRAM size.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, req_addr[31:ADDR_W+2]};

  assign req_ok = is_legal(req_store, req_funct3) && is_aligned(req_funct3, req_addr[1:0]);

  lsu_byte_lane #(.WIDTH(WIDTH)) u_lane (
    .word       (mem_rdata),
    .lane       (cap_lane),
    .funct3     (cap_funct3),
    .wdata      (cap_wdata),
    .load_value (lane_load),
    .store_word (lane_merged)
  );

  // Control FSM; all outputs are registered and strobes last exactly one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      req_ready        <= 1'b1;
      resp_valid       <= 1'b0;
      resp_error       <= 1'b0;
      resp_rdata       <= '0;
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_addr         <= '0;
      mem_wdata        <= '0;
      cap_lane         <= '0;
      cap_funct3       <= '0;
      cap_store        <= 1'b0;
      cap_wdata        <= '0;
    end else begin
      resp_valid       <= 1'b0;
      resp_error       <= 1'b0;
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready  <= 1'b0;
            cap_lane   <= req_addr[1:0];
            cap_funct3 <= req_funct3;
            cap_store  <= req_store;
            cap_wdata  <= req_wdata;
            mem_addr   <= req_addr[ADDR_W+1:2];
            if (!req_ok) begin
              state      <= ERR;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= '0;
            end else if (req_store && (req_funct3 == F3_W)) begin
              state            <= WR;
              mem_write_enable <= 1'b1;
              mem_wdata        <= req_wdata;
            end else begin
              state           <= RD;
              mem_read_enable <= 1'b1;
            end
          end
        end
        RD: state <= CAP;
        CAP: begin
          if (cap_store) begin
            state            <= WR;
            mem_wdata        <= lane_merged;
            mem_write_enable <= 1'b1;
          end else begin
            state      <= RESP;
            resp_rdata <= lane_load;
            resp_valid <= 1'b1;
          end
        end
        WR: begin
          state      <= RESP;
          resp_rdata <= '0;
          resp_valid <= 1'b1;
        end
        RESP, ERR: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a BRAM model and a response scoreboard.
module tb_load_store_unit;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 7;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_store = 1'b0;
  logic [2:0]        req_funct3 = 3'b000;
  logic [31:0]       req_addr = '0;
  logic [WIDTH-1:0]  req_wdata = '0;
  logic              resp_valid;
  logic [WIDTH-1:0]  resp_rdata;
  logic              resp_error;
  logic              mem_read_enable;
  logic              mem_write_enable;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic [WIDTH-1:0]  mem_rdata = '0;

  load_store_unit #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_store        (req_store),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_error       (resp_error),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          wr_cyc = 0;
  logic [31:0] wr_data = '0;
  logic [6:0]  rd_addr = '0;

  logic [31:0] mem [0:127];
  logic        pre_we = 1'b0;
  logic [6:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  // BRAM model: synchronous read, plain word write, plus a bench preload port.
  always @(posedge clock) begin
    if (mem_read_enable) mem_rdata <= mem[mem_addr];
    if (mem_write_enable) mem[mem_addr] <= mem_wdata;
    if (pre_we) mem[pre_addr] <= pre_data;
  end

  // Cycle counter and acceptance timestamp.
  always @(posedge clock) begin
    if (reset && req_valid && req_ready) acc_cyc = cyc;
    cyc = cyc + 1;
  end

  // Response monitor and strobe accounting.
  always @(negedge clock) begin
    exp_t e;
    if (mem_read_enable) begin
      rd_cnt++;
      rd_addr = mem_addr;
    end
    if (mem_write_enable) begin
      wr_cnt++;
      wr_cyc  = cyc;
      wr_data = mem_wdata;
    end
    if (resp_valid) begin
      checks++;
      assert (sb_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_resp observed %h expected none", resp_rdata);
      end
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk({e.tag, "_rdata"}, resp_rdata, e.rdata);
        chk({e.tag, "_err"}, {31'd0, resp_error}, {31'd0, e.err});
        chk({e.tag, "_lat"}, cyc - acc_cyc, e.lat);
      end
    end
  end

  task automatic preload(input logic [6:0] a, input logic [31:0] d);
    @(negedge clock);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clock);
    #1 pre_we = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 12 && sb_q.size() != 0; i++) @(negedge clock);
    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL %s_timeout observed %0d expected 0", tag, sb_q.size());
      sb_q.delete();
    end
    @(negedge clock);
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd,
                       input logic exp_err, input int lat, input string tag);
    exp_t e;
    @(negedge clock);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    e.rdata = exp_rd; e.err = exp_err; e.lat = lat; e.tag = tag;
    sb_q.push_back(e);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clock);
    #1 req_valid = 1'b0;
    wait_done(tag);
  endtask

  initial begin
    int rd0, wr0;
    // Reset state
    #12;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_error", {31'd0, resp_error}, 32'd0);
    chk("rst_rd_en", {31'd0, mem_read_enable}, 32'd0);
    chk("rst_wr_en", {31'd0, mem_write_enable}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_addr", {25'd0, mem_addr}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    preload(7'd4, 32'h8899AABB);
    preload(7'd5, 32'h00000000);
    preload(7'd3, 32'h0BADF00D);

    // Loads
    issue(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF88, 1'b0, 3, "lb");
    issue(1'b0, 3'b100, 32'h13, 32'h0, 32'h00000088, 1'b0, 3, "lbu");
    issue(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF8899, 1'b0, 3, "lh");
    issue(1'b0, 3'b101, 32'h10, 32'h0, 32'h0000AABB, 1'b0, 3, "lhu");
    issue(1'b0, 3'b010, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 3, "lw");

    // SB read-modify-write
    rd0 = rd_cnt; wr0 = wr_cnt;
    issue(1'b1, 3'b000, 32'h11, 32'h12345678, 32'h0, 1'b0, 4, "sb");
    chk("sb_reads", rd_cnt - rd0, 1);
    chk("sb_writes", wr_cnt - wr0, 1);
    chk("sb_wdata", wr_data, 32'h889978BB);
    chk("sb_mem", mem[4], 32'h889978BB);

    // SH on a fresh word, then SW
    preload(7'd4, 32'h8899AABB);
    issue(1'b1, 3'b001, 32'h12, 32'h0000CAFE, 32'h0, 1'b0, 4, "sh");
    chk("sh_mem", mem[4], 32'hCAFEAABB);
    rd0 = rd_cnt; wr0 = wr_cnt;
    issue(1'b1, 3'b010, 32'h14, 32'hDEADBEEF, 32'h0, 1'b0, 2, "sw");
    chk("sw_reads", rd_cnt - rd0, 0);
    chk("sw_writes", wr_cnt - wr0, 1);
    chk("sw_wr_cycle", wr_cyc - acc_cyc, 1);
    chk("sw_mem", mem[5], 32'hDEADBEEF);

    // Error cases
    rd0 = rd_cnt; wr0 = wr_cnt;
    issue(1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1, 1, "lw_misal");
    issue(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, "ld_f3_011");
    issue(1'b1, 3'b001, 32'h13, 32'h0000BEEF, 32'h0, 1'b1, 1, "sh_misal");
    issue(1'b1, 3'b100, 32'h10, 32'h0, 32'h0, 1'b1, 1, "st_f3_100");
    chk("err_reads", rd_cnt - rd0, 0);
    chk("err_writes", wr_cnt - wr0, 0);
    chk("err_mem4", mem[4], 32'hCAFEAABB);

    // Reset during the WR cycle of an SB
    preload(7'd4, 32'h8899AABB);
    @(negedge clock);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000; req_addr = 32'h11; req_wdata = 32'h12345678;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2;
    chk("abort_we_before", {31'd0, mem_write_enable}, 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_we_after", {31'd0, mem_write_enable}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_mem", mem[4], 32'h8899AABB);
    repeat (6) @(negedge clock);

    // Back-to-back with req_valid held, second request aliases to word 3
    begin
      exp_t e;
      e.rdata = 32'h8899AABB; e.err = 1'b0; e.lat = 3; e.tag = "b2b_first";
      sb_q.push_back(e);
      req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
      @(posedge clock);
      for (int i = 1; i <= 3; i++) begin
        @(negedge clock);
        chk("b2b_busy", {31'd0, req_ready}, 32'd0);
        if (i == 1) begin
          e.rdata = 32'h0BADF00D; e.err = 1'b0; e.lat = 3; e.tag = "b2b_alias";
          sb_q.push_back(e);
          req_addr = 32'h20C;
        end
      end
      @(negedge clock);
      chk("b2b_idle_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clock);
      #1 req_valid = 1'b0;
      wait_done("b2b");
      chk("alias_rd_addr", {25'd0, rd_addr}, 32'd3);
    end

    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
